// File: rtl/countdown_timer_ctrl.sv
// Two-digit BCD countdown sequencer for the right-hand display digits.
// Produces {enable, tens, ones} for the display driver and a one-cycle expiry pulse.
module countdown_timer_ctrl #(
  parameter int TICK_DIV = 10000,
  parameter int HOLD_SEC = 2
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] load_bcd,
  input  logic       cancel,
  input  logic       pause,
  output logic [8:0] seconds,
  output logic       timeout,
  output logic       busy,
  output logic       load_err
);

  // state   | meaning
  // IDLE    | display blanked, waiting for start
  // RUN     | counting down, tick counter advancing
  // PAUSE   | count and tick counter frozen while pause is high
  // EXPIRED | "00" held for HOLD_SEC seconds before blanking
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_SEC > 2) ? $clog2(HOLD_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SEC - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [8:0]    seconds_nxt;
  logic          timeout_nxt, busy_nxt, load_err_nxt;
  logic          sec_tick, load_ok;
  logic [7:0]    dec_bcd;

  assign sec_tick = ((state == RUN) || (state == EXPIRED)) && (tick == TICK_LAST);
  assign load_ok  = (load_bcd[7:4] <= 4'd9) && (load_bcd[3:0] <= 4'd9) && (load_bcd != 8'h00);
  // BCD borrow from tens when ones is already zero
  assign dec_bcd  = (seconds[3:0] == 4'd0) ? {seconds[7:4] - 4'd1, 4'd9}
                                           : {seconds[7:4], seconds[3:0] - 4'd1};

  always_comb begin
    state_nxt    = state;
    tick_nxt     = tick;
    hold_nxt     = hold;
    seconds_nxt  = seconds;
    timeout_nxt  = 1'b0;
    load_err_nxt = 1'b0;
    if (cancel) begin
      if (state != IDLE) begin
        state_nxt   = IDLE;
        seconds_nxt = 9'h000;
        tick_nxt    = '0;
        hold_nxt    = '0;
      end
    end else if (start) begin
      if (load_ok) begin
        state_nxt   = RUN;
        seconds_nxt = {1'b1, load_bcd};
        tick_nxt    = '0;
        hold_nxt    = '0;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          if (sec_tick) begin
            // a pause arriving with the tick still takes the decrement
            tick_nxt    = '0;
            seconds_nxt = {1'b1, dec_bcd};
            if (seconds[7:0] == 8'h01) begin
              state_nxt   = EXPIRED;
              timeout_nxt = 1'b1;
              hold_nxt    = '0;
            end else if (pause) begin
              state_nxt = PAUSE;
            end
          end else if (pause) begin
            state_nxt = PAUSE;
          end else begin
            tick_nxt = tick + 1'b1;
          end
        end
        PAUSE: begin
          if (!pause) state_nxt = RUN;
        end
        EXPIRED: begin
          if (HOLD_SEC == 0) begin
            state_nxt   = IDLE;
            seconds_nxt = 9'h000;
          end else if (sec_tick) begin
            tick_nxt = '0;
            if (hold == HOLD_LAST) begin
              state_nxt   = IDLE;
              seconds_nxt = 9'h000;
              hold_nxt    = '0;
            end else begin
              hold_nxt = hold + 1'b1;
            end
          end else begin
            tick_nxt = tick + 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
  end

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick     <= '0;
      hold     <= '0;
      seconds  <= 9'h000;
      timeout  <= 1'b0;
      busy     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick     <= tick_nxt;
      hold     <= hold_nxt;
      seconds  <= seconds_nxt;
      timeout  <= timeout_nxt;
      busy     <= busy_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed scenarios then random commands,
// checked against a decimal-arithmetic model of the countdown.
module tb_countdown_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int HOLD_SEC = 2;

  logic       clk_out = 1'b0;
  logic       reset;
  logic       start, cancel, pause;
  logic [7:0] load_bcd;
  logic [8:0] seconds;
  logic       timeout, busy, load_err;

  int vectors = 0;
  int miscompares = 0;

  // model: 0 idle, 1 counting, 2 paused, 3 showing expired "00"
  int         m_mode, m_val, m_phase, m_held;
  logic       m_en;
  logic [8:0] e_sec;
  logic       e_to, e_busy, e_err;

  countdown_timer_ctrl #(.TICK_DIV(TICK_DIV), .HOLD_SEC(HOLD_SEC)) dut (
    .clk_out(clk_out), .reset(reset), .start(start), .load_bcd(load_bcd),
    .cancel(cancel), .pause(pause), .seconds(seconds), .timeout(timeout),
    .busy(busy), .load_err(load_err)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_val = 0; m_phase = 0; m_held = 0; m_en = 1'b0;
    e_sec = 9'h000; e_to = 1'b0; e_busy = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic [7:0] ld, input logic cn, input logic ps);
    bit legal;
    e_to  = 1'b0;
    e_err = 1'b0;
    legal = (ld[7:4] <= 9) && (ld[3:0] <= 9) && (ld != 8'h00);
    if (cn) begin
      if (m_mode != 0) begin m_mode = 0; m_val = 0; m_en = 1'b0; end
    end else if (st) begin
      if (legal) begin
        m_mode = 1; m_val = ld[7:4] * 10 + ld[3:0]; m_en = 1'b1; m_phase = 0; m_held = 0;
      end else e_err = 1'b1;
    end else if (m_mode == 1) begin
      if (m_phase == TICK_DIV - 1) begin
        m_phase = 0;
        m_val   = m_val - 1;
        if (m_val == 0) begin m_mode = 3; m_held = 0; e_to = 1'b1; end
        else if (ps) m_mode = 2;
      end else if (ps) m_mode = 2;
      else m_phase++;
    end else if (m_mode == 2) begin
      if (!ps) m_mode = 1;
    end else if (m_mode == 3) begin
      if (m_phase == TICK_DIV - 1) begin
        m_phase = 0;
        m_held++;
        if (m_held == HOLD_SEC) begin m_mode = 0; m_val = 0; m_en = 1'b0; end
      end else m_phase++;
    end
    e_sec  = {m_en, 4'(m_val / 10), 4'(m_val % 10)};
    e_busy = (m_mode == 1) || (m_mode == 2);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".seconds"}, seconds, e_sec);
    chk({tag, ".timeout"}, {8'h00, timeout}, {8'h00, e_to});
    chk({tag, ".busy"}, {8'h00, busy}, {8'h00, e_busy});
    chk({tag, ".load_err"}, {8'h00, load_err}, {8'h00, e_err});
  endtask

  task automatic cycle(input string tag, input logic st, input logic [7:0] ld,
                       input logic cn, input logic ps);
    start = st; load_bcd = ld; cancel = cn; pause = ps;
    model_step(st, ld, cn, ps);
    @(posedge clk_out);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic ps);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 8'h00, 1'b0, ps);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cancel = 1'b0; pause = 1'b0; load_bcd = 8'h00;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk_out);
    reset = 1'b1;

    // basic countdown through expiry and hold
    cycle("load03", 1'b1, 8'h03, 1'b0, 1'b0);
    chk("load03.direct", seconds, 9'h103);
    idle("run03", 22, 1'b0);

    // ones borrow from tens
    cycle("load10", 1'b1, 8'h10, 1'b0, 1'b0);
    idle("run10", 4, 1'b0);
    chk("borrow10.direct", seconds, 9'h109);
    cycle("load90", 1'b1, 8'h90, 1'b0, 1'b0);
    idle("run90", 4, 1'b0);
    chk("borrow90.direct", seconds, 9'h189);
    cycle("cancel", 1'b0, 8'h00, 1'b1, 1'b0);

    // illegal loads from IDLE
    cycle("ill00", 1'b1, 8'h00, 1'b0, 1'b0);
    cycle("ill1A", 1'b1, 8'h1A, 1'b0, 1'b0);
    cycle("illA1", 1'b1, 8'hA1, 1'b0, 1'b0);
    idle("after_ill", 2, 1'b0);

    // pause holds count and preserves tick phase
    cycle("load05", 1'b1, 8'h05, 1'b0, 1'b0);
    idle("pre_pause", 2, 1'b0);
    idle("paused", 20, 1'b1);
    idle("resume", 8, 1'b0);

    // cancel beats start in the same cycle
    cycle("load07", 1'b1, 8'h07, 1'b0, 1'b0);
    idle("run07", 2, 1'b0);
    cycle("cancel_start", 1'b1, 8'h09, 1'b1, 1'b0);
    idle("post_cancel", 3, 1'b0);

    // restart from EXPIRED
    cycle("load01", 1'b1, 8'h01, 1'b0, 1'b0);
    idle("run01", 5, 1'b0);
    cycle("restart02", 1'b1, 8'h02, 1'b0, 1'b0);
    idle("run02", 18, 1'b0);

    // asynchronous reset mid-count
    cycle("load42", 1'b1, 8'h42, 1'b0, 1'b0);
    idle("run42", 3, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk_out);
    reset = 1'b1;
    idle("post_reset", 6, 1'b0);

    // random command mix
    for (int i = 0; i < 600; i++) begin
      logic st, cn, ps;
      logic [7:0] ld;
      st = ($urandom_range(0, 19) == 0);
      cn = ($urandom_range(0, 39) == 0);
      ps = ($urandom_range(0, 5) == 0);
      ld = ($urandom_range(0, 4) == 0) ? 8'($urandom) :
           {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
      cycle("rand", st, ld, cn, ps);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
